inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 26 ++
 rtl/inst_fetch.sv | 91 +++++++++
 tb/tb_inst_fetch.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: decode-side controls, instruction ROM port and
// the instruction/pc pair presented to decode.
interface inst_fetch_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  // Fetch unit side
  modport master (
    input  stall_i, flush_i, new_pc_i, rom_ack_i, rom_data_i,
    output rom_req_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
  );

  // Environment side (decode stage + instruction memory)
  modport slave (
    output stall_i, flush_i, new_pc_i, rom_ack_i, rom_data_i,
    input  rom_req_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch PC, DEPTH-entry prefetch FIFO of
// {pc, inst} pairs, single-cycle ROM handshake and flush redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  // DEPTH is 2 or 4, so pointers wrap naturally at their width
  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];

  logic full, empty, req, push, pop, valid;

  // Handshake decode and decode-side outputs
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    req   = !rst && !bus.flush_i && !full;
    push  = req && bus.rom_ack_i;
    pop   = !rst && !empty && !bus.stall_i && !bus.flush_i;
    valid = !rst && !empty;

    bus.rom_req_o  = req;
    bus.rom_addr_o = pc_q;
    bus.id_valid_o = valid;
    bus.id_pc_o    = valid ? fifo_pc_q[head_q]   : '0;
    bus.id_inst_o  = valid ? fifo_inst_q[head_q] : '0;
  end

  // Next-state for fetch PC, pointers and occupancy; flush wins over push/pop
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.flush_i) begin
      pc_d    = {bus.new_pc_i[31:2], 2'b00};
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and FIFO storage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) begin
        fifo_pc_q[tail_q]   <= pc_q;
        fifo_inst_q[tail_q] <= bus.rom_data_i;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk;
  logic        rst, stall, flush, ack;
  logic [31:0] new_pc, key;
  int          checks = 0;
  int          errors = 0;

  inst_fetch_if ifc();

  assign ifc.stall_i    = stall;
  assign ifc.flush_i    = flush;
  assign ifc.new_pc_i   = new_pc;
  assign ifc.rom_ack_i  = ack;
  // ROM content: word = address ^ key
  assign ifc.rom_data_i = ifc.rom_addr_o ^ key;

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of {pc, inst}, plus the fetch address
  logic [63:0] mq [$];
  logic [31:0] m_pc;

  function automatic void model_clock();
    bit can_req;
    if (rst) begin
      m_pc = RESET_PC;
      mq.delete();
    end else if (flush) begin
      mq.delete();
      m_pc = new_pc & 32'hFFFF_FFFC;
    end else begin
      can_req = (mq.size() < int'(DEPTH));
      if (mq.size() != 0 && !stall) void'(mq.pop_front());
      if (can_req && ack) begin
        mq.push_back({m_pc, m_pc ^ key});
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  function automatic logic exp_req();
    return !rst && !flush && (mq.size() < int'(DEPTH));
  endfunction
  function automatic logic exp_valid();
    return !rst && (mq.size() != 0);
  endfunction
  function automatic logic [31:0] exp_pc();
    logic [63:0] e;
    if (!exp_valid()) return 32'h0;
    e = mq[0];
    return e[63:32];
  endfunction
  function automatic logic [31:0] exp_inst();
    logic [63:0] e;
    if (!exp_valid()) return 32'h0;
    e = mq[0];
    return e[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'(($urandom)); flush = 1'b0; ack = 1'b1;
    key = 32'h0; new_pc = 32'h0;
    tick(); tick();
    checks += 4;
    if (ifc.rom_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", ifc.rom_req_o); end
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifc.id_valid_o); end
    if (ifc.id_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", ifc.id_pc_o); end
    if (ifc.id_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", ifc.id_inst_o); end
    rst = 1'b0; stall = 1'b0; ack = 1'b0;
    #1;
    checks += 3;
    if (ifc.rom_req_o !== 1'b1) begin errors++; $display("FAIL post_rst_req got %b exp 1", ifc.rom_req_o); end
    if (ifc.rom_addr_o !== RESET_PC) begin errors++; $display("FAIL post_rst_addr got %h exp %h", ifc.rom_addr_o, RESET_PC); end
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", ifc.id_valid_o); end
  endtask

  task automatic test_streaming();
    ack = 1'b1; stall = 1'b0; key = 32'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks += 4;
      if (ifc.id_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, ifc.id_valid_o); end
      if (ifc.id_pc_o !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, ifc.id_pc_o, 32'(i * 4)); end
      if (ifc.id_inst_o !== 32'(i * 4)) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", i, ifc.id_inst_o, 32'(i * 4)); end
      if (ifc.rom_addr_o !== 32'((i + 1) * 4)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, ifc.rom_addr_o, 32'((i + 1) * 4)); end
    end
  endtask

  task automatic test_stall_fill();
    logic [31:0] held;
    held = exp_pc();
    stall = 1'b1; ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (ifc.id_pc_o !== held) begin errors++; $display("FAIL stall_hold_pc[%0d] got %h exp %h", i, ifc.id_pc_o, held); end
      if (ifc.id_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[%0d] got %b exp 1", i, ifc.id_valid_o); end
    end
    checks += 2;
    if (ifc.rom_req_o !== 1'b0) begin errors++; $display("FAIL stall_full_req got %b exp 0", ifc.rom_req_o); end
    if (ifc.rom_addr_o !== held + 32'(DEPTH * 4)) begin errors++; $display("FAIL stall_full_addr got %h exp %h", ifc.rom_addr_o, held + 32'(DEPTH * 4)); end
    stall = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (ifc.id_pc_o !== held + 32'(k * 4)) begin errors++; $display("FAIL stall_release_pc[%0d] got %h exp %h", k, ifc.id_pc_o, held + 32'(k * 4)); end
      if (ifc.id_valid_o !== 1'b1) begin errors++; $display("FAIL stall_release_valid[%0d] got %b exp 1", k, ifc.id_valid_o); end
      tick();
    end
  endtask

  task automatic test_flush();
    key = $urandom;
    stall = 1'b1; ack = 1'b1;
    tick(); tick(); tick();
    checks += 1;
    if (mq.size() != 2 || ifc.rom_req_o !== 1'b0) begin errors++; $display("FAIL flush_prefill req got %b exp 0", ifc.rom_req_o); end
    flush = 1'b1; new_pc = 32'h0000_0103;
    #1;
    checks += 1;
    if (ifc.rom_req_o !== 1'b0) begin errors++; $display("FAIL flush_req_low got %b exp 0", ifc.rom_req_o); end
    tick();
    flush = 1'b0; stall = 1'b0; ack = 1'b1;
    #1;
    checks += 3;
    if (ifc.rom_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL flush_addr got %h exp 00000100", ifc.rom_addr_o); end
    if (ifc.rom_req_o !== 1'b1) begin errors++; $display("FAIL flush_req got %b exp 1", ifc.rom_req_o); end
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale_valid got %b exp 0", ifc.id_valid_o); end
    tick();
    checks += 3;
    if (ifc.id_valid_o !== 1'b1) begin errors++; $display("FAIL flush_tgt_valid got %b exp 1", ifc.id_valid_o); end
    if (ifc.id_pc_o !== 32'h0000_0100) begin errors++; $display("FAIL flush_tgt_pc got %h exp 00000100", ifc.id_pc_o); end
    if (ifc.id_inst_o !== (32'h0000_0100 ^ key)) begin errors++; $display("FAIL flush_tgt_inst got %h exp %h", ifc.id_inst_o, 32'h0000_0100 ^ key); end
  endtask

  task automatic test_collision();
    logic [31:0] tgt;
    tgt = $urandom & 32'hFFFF_FFFC;
    stall = 1'b0; ack = 1'b1; flush = 1'b1; new_pc = tgt;
    tick();
    flush = 1'b0; ack = 1'b0;
    #1;
    checks += 3;
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL collide_valid got %b exp 0", ifc.id_valid_o); end
    if (ifc.rom_addr_o !== tgt) begin errors++; $display("FAIL collide_addr got %h exp %h", ifc.rom_addr_o, tgt); end
    if (ifc.id_pc_o !== 32'h0) begin errors++; $display("FAIL collide_pc got %h exp 0", ifc.id_pc_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [3];
    seq[0] = 32'hFFFF_FFF8; seq[1] = 32'hFFFF_FFFC; seq[2] = 32'h0000_0000;
    stall = 1'b0; ack = 1'b1; flush = 1'b1; new_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks += 1;
      if (ifc.rom_addr_o !== seq[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, ifc.rom_addr_o, seq[i]); end
      if (i == 2) begin
        checks += 1;
        if (ifc.id_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_id_pc got %h exp FFFFFFFC", ifc.id_pc_o); end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    stall = 1'b1; ack = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks += 1;
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_during_valid got %b exp 0", ifc.id_valid_o); end
    tick();
    rst = 1'b0; ack = 1'b0;
    #1;
    checks += 2;
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", ifc.id_valid_o); end
    if (ifc.rom_addr_o !== RESET_PC) begin errors++; $display("FAIL midrst_addr got %h exp %h", ifc.rom_addr_o, RESET_PC); end
    stall = 1'b0;
    tick();
    checks += 1;
    if (ifc.id_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_stale got %b exp 0", ifc.id_valid_o); end
  endtask

  task automatic test_random();
    key = $urandom;
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      stall  = ($urandom_range(0, 2) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      ack    = ($urandom_range(0, 2) != 0);
      new_pc = $urandom;
      #1;
      checks += 5;
      if (ifc.rom_req_o !== exp_req()) begin errors++; $display("FAIL rand_req[%0d] got %b exp %b", i, ifc.rom_req_o, exp_req()); end
      if (ifc.rom_addr_o !== m_pc) begin errors++; $display("FAIL rand_addr[%0d] got %h exp %h", i, ifc.rom_addr_o, m_pc); end
      if (ifc.id_valid_o !== exp_valid()) begin errors++; $display("FAIL rand_valid[%0d] got %b exp %b", i, ifc.id_valid_o, exp_valid()); end
      if (ifc.id_pc_o !== exp_pc()) begin errors++; $display("FAIL rand_pc[%0d] got %h exp %h", i, ifc.id_pc_o, exp_pc()); end
      if (ifc.id_inst_o !== exp_inst()) begin errors++; $display("FAIL rand_inst[%0d] got %h exp %h", i, ifc.id_inst_o, exp_inst()); end
      tick();
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ack = 1'b0;
    new_pc = 32'h0; key = 32'h0;
    m_pc = RESET_PC;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_collision();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
